// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//
// Purpose:
//   This block widens an IN_W-bit immediate to OUT_W bits for the ALU and
//   branch-target datapath. Results go into a 2-entry FIFO. Both sides of the
//   FIFO use valid/ready handshakes, so decode and execute can stall
//   independently of each other.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_imm/in_mode carry a request this cycle
//   in_ready   block accepts a request this cycle
//               (depends only on the registered count)
//   in_imm     raw immediate, IN_W bits
//   in_mode    00 sign-ext, 01 zero-ext, 10 sign-ext << SHIFT, 11 upper-load
//   out_valid  out_data/out_sign hold the head entry
//   out_ready  consumer takes the head entry this cycle
//   out_data   extended result at the head of the queue (0 when empty)
//   out_sign   MSB of the original immediate of the head entry (0 when empty)
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sign
);

  // Reject parameter sets that cannot hold the shifted result.
  generate
    if (IN_W < 2) begin : g_bad_in_w
      $fatal(1, "imm_extend_pipe: IN_W must be >= 2");
    end
    if (OUT_W < IN_W + SHIFT) begin : g_bad_out_w
      $fatal(1, "imm_extend_pipe: OUT_W must be >= IN_W + SHIFT");
    end
  endgenerate

  localparam int EW = OUT_W + 1;  // stored entry: {sign, data}

  // ---------------------------------------------------------------------------
  // Extension arithmetic
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext_res;

  always_comb begin
    // The size casts also cover OUT_W == IN_W, where a zero-width
    // replication would be illegal.
    sext = OUT_W'($signed(in_imm));
    zext = OUT_W'(in_imm);
    case (in_mode)
      2'b00:   ext_res = sext;
      2'b01:   ext_res = zext;
      2'b10:   ext_res = sext << SHIFT;
      default: ext_res = zext << (OUT_W - IN_W);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-entry queue. Entry 0 is always the head.
  // ---------------------------------------------------------------------------
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] ent_q [2];
  logic [EW-1:0] ent_d [2];
  logic [EW-1:0] new_ent;
  logic          push;
  logic          pop;

  assign new_ent   = {in_imm[IN_W-1], ext_res};
  assign out_valid = (count_q != 2'd0);
  // Only the registered count and the reset gate this signal.
  // out_ready has no path to it, so a FULL queue refuses a push even
  // in a cycle where it pops.
  assign in_ready  = !rst && (count_q != 2'd2);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    case (count_q)
      2'd0: begin
        if (push) begin
          ent_d[0] = new_ent;
          count_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // The head leaves and the new entry takes its place.
          ent_d[0] = new_ent;
        end else if (push) begin
          ent_d[1] = new_ent;
          count_d  = 2'd2;
        end else if (pop) begin
          count_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          ent_d[0] = ent_q[1];
          count_d  = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  // A popped head is left in place, so mask the outputs when the queue is
  // empty.
  assign out_data = out_valid ? ent_q[0][OUT_W-1:0] : '0;
  assign out_sign = out_valid ? ent_q[0][OUT_W]     : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  localparam int IW = 16;
  localparam int OW = 32;
  localparam int SH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_imm = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_sign;

  // Second instance with the alternate parametrisation: IN_W=12, OUT_W=16,
  // SHIFT=1.
  logic          a_in_valid = 1'b0;
  logic          a_in_ready;
  logic [11:0]   a_in_imm = '0;
  logic [1:0]    a_in_mode = 2'b00;
  logic          a_out_valid;
  logic          a_out_ready = 1'b1;
  logic [15:0]   a_out_data;
  logic          a_out_sign;

  int total = 0;
  int bad   = 0;

  // Reference queue of expected {sign, data}.
  logic [OW:0] exp_q[$];

  imm_extend_pipe #(.IN_W(IW), .OUT_W(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sign(out_sign)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(16), .SHIFT(1)) dut_alt (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_sign(a_out_sign)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // The reference works from integer arithmetic: it treats the immediate
  // as a signed or unsigned number, scales it, and reduces it modulo 2^ow.
  function automatic longint ref_ext(longint imm, int mode, int iw, int ow, int sh);
    longint m;
    longint sv;
    longint r;
    m  = longint'(1) << ow;
    sv = (imm >= (longint'(1) << (iw - 1))) ? imm - (longint'(1) << iw) : imm;
    case (mode)
      0:       r = sv;
      1:       r = imm;
      2:       r = sv * (longint'(1) << sh);
      default: r = imm * (longint'(1) << (ow - iw));
    endcase
    r = r % m;
    if (r < 0) r = r + m;
    return r;
  endfunction

  // This task advances one clock. It first applies the current inputs to
  // the reference queue.
  task automatic tick();
    bit m_ready;
    bit m_valid;
    longint e;
    m_ready = !rst && (exp_q.size() < 2);
    m_valid = (exp_q.size() > 0);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) void'(exp_q.pop_front());
      if (in_valid && m_ready) begin
        e = ref_ext(longint'(in_imm), int'(in_mode), IW, OW, SH);
        exp_q.push_back({in_imm[IW-1], e[OW-1:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      total++;
      if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    total++;
    if (out_sign !== 1'b0) begin bad++; $display("FAIL post_reset_out_sign: got %b expected 0", out_sign); end
    $display("test_reset done");
  endtask

  task automatic test_modes();
    logic [31:0] exp_neg [4];
    exp_neg[0] = 32'hFFFF8004;
    exp_neg[1] = 32'h00008004;
    exp_neg[2] = 32'hFFFE0010;
    exp_neg[3] = 32'h80040000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_imm = 16'h8004; in_mode = 2'(i);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_neg[i] || out_sign !== 1'b1) begin
        bad++;
        $display("FAIL mode%0d_8004: got v=%b d=%h s=%b expected v=1 d=%h s=1",
                 i, out_valid, out_data, out_sign, exp_neg[i]);
      end else $display("mode %0d imm 8004 -> %h", i, out_data);
    end
    in_imm = 16'h7FFF; in_mode = 2'b00;
    tick();
    total++;
    if (out_data !== 32'h00007FFF || out_sign !== 1'b0) begin
      bad++; $display("FAIL mode0_7fff: got d=%h s=%b expected d=00007fff s=0", out_data, out_sign);
    end else $display("mode 0 imm 7fff -> %h", out_data);
    in_mode = 2'b10;
    tick();
    total++;
    if (out_data !== 32'h0001FFFC || out_sign !== 1'b0) begin
      bad++; $display("FAIL mode2_7fff: got d=%h s=%b expected d=0001fffc s=0", out_data, out_sign);
    end else $display("mode 2 imm 7fff -> %h", out_data);
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      bad++; $display("FAIL modes_drain: got v=%b d=%h expected v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h0001;
    tick();
    in_imm = 16'h0002;
    tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
    in_imm = 16'h0003;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_data !== 32'h1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold_head: got v=%b d=%h expected v=1 d=00000001", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== 32'h2 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_second: got d=%h rdy=%b expected d=00000002 rdy=1", out_data, in_ready);
    end else $display("backpressure second result %h", out_data);
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_third_ignored: got v=%b d=%h expected v=0", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_imm = 16'($urandom);
      in_mode = 2'($urandom_range(0, 3));
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
          out_data !== exp_q[0][OW-1:0] || out_sign !== exp_q[0][OW]) begin
        bad++;
        $display("FAIL b2b_%0d: got v=%b rdy=%b d=%h s=%b expected v=1 rdy=1 d=%h s=%b",
                 i, out_valid, in_ready, out_data, out_sign, exp_q[0][OW-1:0], exp_q[0][OW]);
      end else $display("b2b %0d -> %h", i, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [OW-1:0] ed;
    logic          es;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      tick();
      ed = (exp_q.size() > 0) ? exp_q[0][OW-1:0] : '0;
      es = (exp_q.size() > 0) ? exp_q[0][OW] : 1'b0;
      total++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) ||
          out_data !== ed || out_sign !== es) begin
        bad++;
        $display("FAIL rand_%0d: got v=%b rdy=%b d=%h s=%b expected v=%b rdy=%b d=%h s=%b",
                 i, out_valid, in_ready, out_data, out_sign,
                 exp_q.size() > 0, exp_q.size() < 2, ed, es);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_imm = 16'h1234; in_mode = 2'b00;
    tick();
    in_imm = 16'h5678;
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rm_full: got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid);
    end
    rst = 1'b1; in_imm = 16'h9ABC; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rm_after: got v=%b d=%h rdy=%b expected v=0 d=0 rdy=1", out_valid, out_data, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL rm_stale_%0d: got v=%b d=%h expected v=0", i, out_valid, out_data);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_alt_params();
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hF800;
    exp_a[1] = 16'h0800;
    exp_a[2] = 16'hF000;
    exp_a[3] = 16'h8000;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_imm = 12'h800; a_in_mode = 2'(i);
      tick();
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp_a[i] || a_out_sign !== 1'b1) begin
        bad++;
        $display("FAIL alt_mode%0d: got v=%b d=%h s=%b expected v=1 d=%h s=1",
                 i, a_out_valid, a_out_data, a_out_sign, exp_a[i]);
      end else $display("alt mode %0d imm 800 -> %h", i, a_out_data);
    end
    a_in_valid = 1'b0;
    tick();
    total++;
    if (a_out_valid !== 1'b0) begin bad++; $display("FAIL alt_drain: got v=%b expected 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_alt_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
